inv_key_schedule_seq: RTL and testbench
=======================================

// Module: inv_key_schedule_seq
// PURPOSE
// Sequential inverse AES-128 key schedule for the decryption datapath. Loads the
// final round key (round NUM_ROUNDS) and walks the schedule backwards, emitting
// round keys NUM_ROUNDS, NUM_ROUNDS-1, ..., 0 one per accepted beat over a
// valid/ready stream. Decryption rounds consume keys in this order.
// PARAMETERS
// NUM_ROUNDS  10  index of the loaded key; also the number of inverse steps
// PORTS
// clk      in   1    single clock; all state on rising edge
// rst      in   1    asynchronous, active-high reset
// start_i  in   1    load request; sampled only in IDLE
// key_i    in   128  round-NUM_ROUNDS key, {row0,row1,row2,row3}, row r = bytes r of col0..col3
// key_o    out  128  current round key, same row-major packing as key_i
// round_o  out  8    round index of key_o
// valid_o  out  1    key_o/round_o valid
// ready_i  in   1    consumer accepts key_o this cycle when valid_o=1
// busy_o   out  1    1 from load until the final key is accepted
// done_o   out  1    one-cycle pulse after round-0 key is accepted
// BEHAVIOUR
// - Reset (async assert): state=IDLE; key_o=0, round_o=0, valid_o=0, busy_o=0, done_o=0.
// - FSM: IDLE -> EMIT on start_i; EMIT -> EMIT on handshake with round_o>0;
//   EMIT -> IDLE on handshake with round_o==0.
// - IDLE & start_i at cycle t: key reg <= key_i, round_o <= NUM_ROUNDS;
//   valid_o=1, busy_o=1 from cycle t+1 with key_o == key_i.
// - Handshake = valid_o & ready_i. In EMIT with round_o=r>0: next cycle key_o =
//   inverse step of current key using Rcon(r); round_o=r-1; valid_o stays 1.
// - Inverse step on columns w0..w3 (col c = byte c of each row):
//   w3'=w3^w2; w2'=w2^w1; w1'=w1^w0; w0'=w0^SubWord(RotWord(w3'))^{Rcon(r),24'h0}.
//   RotWord({a,b,c,d})={b,c,d,a}; SubWord uses the forward S-box (sub_word,
//   enc_or_dec_i tied 1). Rcon(1..10)=01,02,04,08,10,20,40,80,1b,36; one step/cycle.
// - Handshake at round_o==0: next cycle valid_o=0, busy_o=0, done_o=1 (one cycle),
//   state IDLE; key_o/round_o hold last values.
// - Backpressure: valid_o & !ready_i holds key_o, round_o, valid_o unchanged.
// - start_i while busy_o=1 (incl. the done_o cycle? no: done_o cycle is IDLE) is
//   ignored. start_i in the done_o cycle is accepted as a new load.
// - Full rate: ready_i held 1 -> NUM_ROUNDS+1 keys on consecutive cycles t+1..t+11.
// - Reset mid-operation: immediate return to reset values; no further output.
// - round_o never wraps below 0; no Rcon(0) is ever applied.
// TESTING
// 1 FIPS-197 key: start_i with key_i=d0c9e1b614ee3f63f9250c0ca889c8a6, ready_i=1 ->
//   round 10 = key_i, round 9 = ac19285777fad15c66dc2900f321416e,
//   round 0 = 2b28ab097eaef7cf15d2154f16a6883c; done_o at t+12; 11 handshakes total.
// 2 Backpressure: same load, ready_i=0 for 5 cycles at round 7 -> key_o/round_o
//   stable; sequence identical to scenario 1, done_o delayed 5 cycles.
// 3 Start while busy: pulse start_i with a different key_i at round 5 -> ignored,
//   output sequence unchanged from scenario 1.
// 4 Reset mid-run: assert rst at round 4 -> valid_o, busy_o, round_o, key_o = 0
//   asynchronously; a new start_i afterwards replays scenario 1 exactly.
// 5 Back-to-back: start_i in the done_o cycle with key_i=0 -> valid_o at next cycle,
//   round 10 key = 0, round 9 key derived with Rcon 36 (matches software model).
// 6 Random: 200 random keys, random ready_i -> all 11 keys match a forward-expansion
//   software model; every round-0 key equals the originating cipher key.

Source files
------------

// File: rtl/inv_key_schedule_seq.sv
// Sequential inverse AES-128 key schedule. Loads the last round key and walks
// the schedule backwards one step per accepted beat, presenting round keys
// NUM_ROUNDS down to 0 on a valid/ready stream.
module inv_key_schedule_seq #(
  parameter int unsigned NUM_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_i,
  input  logic [127:0] key_i,
  output logic [127:0] key_o,
  output logic [7:0]   round_o,
  output logic         valid_o,
  input  logic         ready_i,
  output logic         busy_o,
  output logic         done_o
);

  typedef enum logic [0:0] {StIdle, StEmit} state_e;

  localparam logic [7:0] LastRound = 8'(NUM_ROUNDS);

  // Forward AES S-box; the inverse schedule recomputes the forward SubWord term.
  localparam logic [7:0] SboxTbl [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
    8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
    8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
    8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
    8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
    8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
    8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
    8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
    8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
    8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
    8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
    8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
    8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
    8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
    8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
    8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
    8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SboxTbl[w[31:24]], SboxTbl[w[23:16]], SboxTbl[w[15:8]], SboxTbl[w[7:0]]};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  // Round constant applied when stepping from round r back to r-1.
  function automatic logic [7:0] rcon(input logic [7:0] r);
    logic [7:0] rc;
    case (r)
      8'd1:    rc = 8'h01;
      8'd2:    rc = 8'h02;
      8'd3:    rc = 8'h04;
      8'd4:    rc = 8'h08;
      8'd5:    rc = 8'h10;
      8'd6:    rc = 8'h20;
      8'd7:    rc = 8'h40;
      8'd8:    rc = 8'h80;
      8'd9:    rc = 8'h1b;
      8'd10:   rc = 8'h36;
      8'd11:   rc = 8'h6c;
      8'd12:   rc = 8'hd8;
      8'd13:   rc = 8'hab;
      8'd14:   rc = 8'h4d;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  state_e       state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [7:0]   round_q, round_d;
  logic         valid_q, valid_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;

  logic [3:0][31:0] cols;
  logic [3:0][31:0] prev_cols;
  logic [127:0]     key_prev;
  logic             hs;

  // Inverse key-schedule step on the current key (columns w0..w3).
  always_comb begin
    cols      = '0;
    prev_cols = '0;
    key_prev  = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        cols[c][31-8*r -: 8] = key_q[127-8*(4*r+c) -: 8];
      end
    end
    prev_cols[3] = cols[3] ^ cols[2];
    prev_cols[2] = cols[2] ^ cols[1];
    prev_cols[1] = cols[1] ^ cols[0];
    prev_cols[0] = cols[0] ^ sub_word(rot_word(prev_cols[3])) ^ {rcon(round_q), 24'h0};
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        key_prev[127-8*(4*r+c) -: 8] = prev_cols[c][31-8*r -: 8];
      end
    end
  end

  assign hs = valid_q & ready_i;

  // Next-state logic: load in idle, step back on each handshake, finish after round 0.
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    round_d = round_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StEmit;
          key_d   = key_i;
          round_d = LastRound;
          valid_d = 1'b1;
          busy_d  = 1'b1;
        end
      end
      StEmit: begin
        if (hs) begin
          if (round_q == 8'd0) begin
            // Key and round hold their last values after the final beat.
            state_d = StIdle;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            key_d   = key_prev;
            round_d = round_q - 8'd1;
          end
        end
      end
    endcase
  end

  // State and registered outputs, cleared asynchronously on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      key_q   <= '0;
      round_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      round_q <= round_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign key_o   = key_q;
  assign round_o = round_q;
  assign valid_o = valid_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;

endmodule

// File: tb/tb_inv_key_schedule_seq.sv
// Bench for inv_key_schedule_seq: directed FIPS-197 scenarios plus random keys
// with random backpressure, checked against a word-array key-expansion model.
module tb_inv_key_schedule_seq;

  localparam int NR = 10;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_i;
  logic         ready_i;
  logic [127:0] key_i;
  logic [127:0] key_o;
  logic [7:0]   round_o;
  logic         valid_o;
  logic         busy_o;
  logic         done_o;

  int n_total = 0;
  int n_bad   = 0;

  logic [7:0]   sbox_tbl [256];
  logic [127:0] exp_rk [0:NR];
  logic [127:0] obs_rk [0:NR];

  always #5 clk = ~clk;

  inv_key_schedule_seq #(.NUM_ROUNDS(NR)) dut (
    .clk     (clk),
    .rst     (rst),
    .start_i (start_i),
    .key_i   (key_i),
    .key_o   (key_o),
    .round_o (round_o),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .busy_o  (busy_o),
    .done_o  (done_o)
  );

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xtime(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return 8'((v << n) | (v >> (8 - n)));
  endfunction

  // S-box from its definition: GF(2^8) inverse followed by the affine map.
  function automatic logic [7:0] sbox_calc(input logic [7:0] a);
    logic [7:0] inv = 8'h00;
    if (a != 8'h00) begin
      for (int x = 1; x < 256; x++) begin
        if (gmul(a, 8'(x)) == 8'h01) inv = 8'(x);
      end
    end
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon_m(input int i);
    logic [7:0] rc = 8'h01;
    for (int k = 1; k < i; k++) rc = xtime(rc);
    return rc;
  endfunction

  // Temporary word of FIPS-197 expansion for word index i.
  function automatic logic [31:0] temp_word(input logic [31:0] prev, input int i);
    logic [31:0] t = prev;
    if (i % 4 == 0) begin
      t = {t[23:0], t[31:24]};
      t = {sbox_tbl[t[31:24]], sbox_tbl[t[23:16]], sbox_tbl[t[15:8]], sbox_tbl[t[7:0]]};
      t = t ^ {rcon_m(i / 4), 24'h0};
    end
    return t;
  endfunction

  // Row-major 128-bit key <-> column words (word c = byte c of each row).
  function automatic logic [3:0][31:0] to_words(input logic [127:0] k);
    logic [3:0][31:0] w;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        w[c][31-8*r -: 8] = k[127-8*(4*r+c) -: 8];
    return w;
  endfunction

  function automatic logic [127:0] from_words(input logic [3:0][31:0] w);
    logic [127:0] k;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        k[127-8*(4*r+c) -: 8] = w[c][31-8*r -: 8];
    return k;
  endfunction

  // Forward expansion from a cipher key; fills exp_rk[0..NR].
  task automatic expand_fwd(input logic [127:0] ck);
    logic [31:0] w [4*NR+4];
    logic [3:0][31:0] ws = to_words(ck);
    for (int i = 0; i < 4; i++) w[i] = ws[i];
    for (int i = 4; i < 4*NR+4; i++) w[i] = w[i-4] ^ temp_word(w[i-1], i);
    for (int r = 0; r <= NR; r++) exp_rk[r] = from_words({w[4*r+3], w[4*r+2], w[4*r+1], w[4*r]});
  endtask

  // Same recurrence solved for w[i-4], starting from the last round's words.
  task automatic expand_bwd(input logic [127:0] last_key);
    logic [31:0] w [4*NR+4];
    logic [3:0][31:0] ws = to_words(last_key);
    for (int i = 0; i < 4; i++) w[4*NR+i] = ws[i];
    for (int i = 4*NR+3; i >= 4; i--) w[i-4] = w[i] ^ temp_word(w[i-1], i);
    for (int r = 0; r <= NR; r++) exp_rk[r] = from_words({w[4*r+3], w[4*r+2], w[4*r+1], w[4*r]});
  endtask

  // ---------------- stimulus ----------------
  // Called at a negedge; loads ld, streams all keys against exp_rk, returns
  // at the negedge of the done_o cycle with cycles = start-to-done count.
  task automatic do_run(input logic [127:0] ld, input int ready_pct, input int stall_at,
                        input int stall_n, input int poke_at, output int cycles);
    int   er      = NR;
    int   stalled = 0;
    bit   poked   = 1'b0;
    logic rdy;
    cycles  = 0;
    start_i = 1'b1;
    key_i   = ld;
    ready_i = 1'b0;
    @(negedge clk);
    start_i = 1'b0;
    cycles  = 1;
    while (er >= 0 && cycles < 2000) begin
      check_eq($sformatf("valid r%0d", er), 128'(valid_o), 128'(1));
      check_eq($sformatf("busy r%0d", er), 128'(busy_o), 128'(1));
      check_eq($sformatf("done r%0d", er), 128'(done_o), 128'(0));
      check_eq($sformatf("round r%0d", er), 128'(round_o), 128'(er));
      check_eq($sformatf("key r%0d", er), key_o, exp_rk[er]);
      obs_rk[er] = key_o;
      if (stall_at == er && stalled < stall_n) begin
        rdy = 1'b0;
        stalled++;
      end else begin
        rdy = ($urandom_range(99) < ready_pct);
      end
      if (poke_at == er && !poked) begin
        start_i = 1'b1;
        key_i   = ~ld;
        poked   = 1'b1;
      end
      ready_i = rdy;
      @(negedge clk);
      cycles++;
      start_i = 1'b0;
      ready_i = 1'b0;
      if (rdy) er--;
    end
    if (er >= 0) begin
      check_eq("run timeout", 128'(cycles), 128'(0));
    end else begin
      check_eq("done pulse", 128'(done_o), 128'(1));
      check_eq("valid after last", 128'(valid_o), 128'(0));
      check_eq("busy after last", 128'(busy_o), 128'(0));
      check_eq("round hold", 128'(round_o), 128'(0));
      check_eq("key hold", key_o, exp_rk[0]);
    end
  endtask

  localparam logic [127:0] FipsCk  = 128'h2b28ab097eaef7cf15d2154f16a6883c;
  localparam logic [127:0] FipsK10 = 128'hd0c9e1b614ee3f63f9250c0ca889c8a6;
  localparam logic [127:0] FipsK9  = 128'hac19285777fad15c66dc2900f321416e;

  initial begin
    int cyc;
    logic [127:0] ck;
    rst     = 1'b1;
    start_i = 1'b0;
    ready_i = 1'b0;
    key_i   = '0;
    for (int i = 0; i < 256; i++) sbox_tbl[i] = sbox_calc(8'(i));

    repeat (2) @(negedge clk);
    check_eq("reset key", key_o, 128'h0);
    check_eq("reset round", 128'(round_o), 128'(0));
    check_eq("reset valid", 128'(valid_o), 128'(0));
    check_eq("reset busy", 128'(busy_o), 128'(0));
    check_eq("reset done", 128'(done_o), 128'(0));
    rst = 1'b0;
    @(negedge clk);

    // 1: FIPS-197 key at full rate
    expand_fwd(FipsCk);
    do_run(FipsK10, 100, -1, 0, -1, cyc);
    check_eq("fips cycles", 128'(cyc), 128'(12));
    check_eq("fips round9", obs_rk[9], FipsK9);
    check_eq("fips round0", obs_rk[0], FipsCk);
    @(negedge clk);
    check_eq("done one cycle", 128'(done_o), 128'(0));
    check_eq("idle valid", 128'(valid_o), 128'(0));

    // 2: backpressure at round 7
    do_run(FipsK10, 100, 7, 5, -1, cyc);
    check_eq("stall cycles", 128'(cyc), 128'(17));
    @(negedge clk);

    // 3: start while busy is ignored
    do_run(FipsK10, 100, -1, 0, 5, cyc);
    check_eq("poke cycles", 128'(cyc), 128'(12));
    @(negedge clk);

    // 4: reset in the middle of a run
    start_i = 1'b1;
    key_i   = FipsK10;
    @(negedge clk);
    start_i = 1'b0;
    ready_i = 1'b1;
    repeat (6) @(negedge clk);
    ready_i = 1'b0;
    check_eq("pre-reset round", 128'(round_o), 128'(4));
    check_eq("pre-reset key", key_o, exp_rk[4]);
    rst = 1'b1;
    #1;
    check_eq("async rst valid", 128'(valid_o), 128'(0));
    check_eq("async rst busy", 128'(busy_o), 128'(0));
    check_eq("async rst round", 128'(round_o), 128'(0));
    check_eq("async rst key", key_o, 128'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("post-rst valid", 128'(valid_o), 128'(0));
    do_run(FipsK10, 100, -1, 0, -1, cyc);
    check_eq("replay cycles", 128'(cyc), 128'(12));

    // 5: back-to-back load of an all-zero last-round key in the done cycle
    expand_bwd(128'h0);
    do_run(128'h0, 100, -1, 0, -1, cyc);
    check_eq("b2b cycles", 128'(cyc), 128'(12));

    // 6: random cipher keys with random backpressure
    for (int n = 0; n < 200; n++) begin
      ck = {$urandom, $urandom, $urandom, $urandom};
      expand_fwd(ck);
      repeat ($urandom_range(2)) @(negedge clk);
      do_run(exp_rk[NR], 60, -1, 0, -1, cyc);
      check_eq($sformatf("rand%0d r0", n), obs_rk[0], ck);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
